// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: opcode constants,
// default NOP/STOP encodings, FSM state encoding, scoreboard entry type
// and a scoreboard match helper.
package pipeline_hazard_ctrl_pkg;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STOP  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_SHIFT = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_BZ    = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_ORI   = 4'd7;
    localparam logic [3:0] OP_NAND  = 4'd8;
    localparam logic [3:0] OP_BNZ   = 4'd9;
    localparam logic [3:0] OP_NOP   = 4'd10;
    localparam logic [3:0] OP_BPZ   = 4'd13;

    localparam logic [3:0] NOP_OP_DEFAULT  = OP_NOP;
    localparam logic [3:0] STOP_OP_DEFAULT = OP_STOP;

    // ori implicitly reads and writes k1
    localparam logic [1:0] REG_K1 = 2'd1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] dest;
    } sb_entry_t;

    function automatic logic sb_match(input sb_entry_t e, input logic [1:0] r);
        return e.valid && (e.dest == r);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_ir_reg_decode.sv
// Register-usage decode of an 8-bit instruction word.
//  ir        in   8  instruction: [7:6]=Rx, [5:4]=Ry, [3:0]=opcode
//  reads_rx  out  1  instruction reads Rx
//  reads_ry  out  1  instruction reads Ry
//  reads_k1  out  1  instruction reads k1 implicitly (ori)
//  writes    out  1  instruction writes a register
//  dest      out  2  destination register when writes=1
module ir_reg_decode
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [7:0] ir,
    output logic       reads_rx,
    output logic       reads_ry,
    output logic       reads_k1,
    output logic       writes,
    output logic [1:0] dest
);

    logic [3:0] op;
    assign op = ir[3:0];

    always_comb begin
        reads_rx = 1'b0;
        reads_ry = 1'b0;
        reads_k1 = 1'b0;
        writes   = 1'b0;
        dest     = ir[7:6];
        case (op)
            OP_ADD, OP_SUB, OP_NAND: begin
                reads_rx = 1'b1;
                reads_ry = 1'b1;
                writes   = 1'b1;
            end
            OP_LOAD: begin
                reads_ry = 1'b1;
                writes   = 1'b1;
            end
            OP_STORE: begin
                reads_rx = 1'b1;
                reads_ry = 1'b1;
            end
            default: begin
                // shift and ori are identified by the low three opcode bits only
                if (op[2:0] == 3'd3) begin
                    reads_rx = 1'b1;
                    writes   = 1'b1;
                end else if (op[2:0] == 3'd7) begin
                    reads_k1 = 1'b1;
                    writes   = 1'b1;
                    dest     = REG_K1;
                end
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline (F, IR1, IR2, IR3, IR4).
// Owns PC/IR1 load controls, IR1 squash and IR2 bubble strobes, detects
// RAW hazards against a 3-entry destination scoreboard (EX, MEM, WB),
// flushes on taken branch, drains and halts on stop, counts stall cycles.
//  clock         in   1      rising-edge clock
//  resetn        in   1      asynchronous active-low reset
//  ir1           in   8      instruction in decode
//  branch_taken  in   1      branch in EX resolved taken
//  pc_write      out  1      PC loads this edge
//  pc_sel        out  1      1 = branch target, 0 = PC+1
//  ir1_load      out  1      IR1 loads this edge
//  ir1_squash    out  1      IR1 loads NOP_OP
//  ir2_bubble    out  1      IR2 loads NOP_OP
//  stall         out  1      decode held for a hazard
//  halted        out  1      processor stopped until reset
//  stall_count   out  CNT_W  saturating stall-cycle count
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter logic [3:0] NOP_OP  = NOP_OP_DEFAULT,
    parameter logic [3:0] STOP_OP = STOP_OP_DEFAULT,
    parameter int         CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [7:0]       ir1,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             ir1_load,
    output logic             ir1_squash,
    output logic             ir2_bubble,
    output logic             stall,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    state_t          state, next_state;
    sb_entry_t [2:0] sb;
    logic      [1:0] drain_cnt;

    logic       dec_rx, dec_ry, dec_k1, dec_wr;
    logic [1:0] dec_dest;
    logic       is_bubble;
    logic       hazard;
    logic       advance;

    ir_reg_decode u_decode (
        .ir       (ir1),
        .reads_rx (dec_rx),
        .reads_ry (dec_ry),
        .reads_k1 (dec_k1),
        .writes   (dec_wr),
        .dest     (dec_dest)
    );

    // A squashed IR1 holds NOP_OP; it must neither hazard nor be recorded
    // even if NOP_OP is overridden to an encoding the decoder treats as a writer.
    assign is_bubble = (ir1[3:0] == NOP_OP);

    always_comb begin
        hazard = 1'b0;
        if (!is_bubble) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (dec_rx && sb_match(sb[i], ir1[7:6])) hazard = 1'b1;
                if (dec_ry && sb_match(sb[i], ir1[5:4])) hazard = 1'b1;
                if (dec_k1 && sb_match(sb[i], REG_K1))   hazard = 1'b1;
            end
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        ir1_load   = 1'b0;
        ir1_squash = 1'b0;
        ir2_bubble = 1'b0;
        stall      = 1'b0;
        halted     = 1'b0;
        advance    = 1'b0;
        next_state = state;
        case (state)
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_DRAIN: begin
                ir1_load   = 1'b1;
                ir1_squash = 1'b1;
                if (drain_cnt == 2'd2) next_state = ST_HALT;
            end
            ST_RUN: begin
                if (branch_taken) begin
                    pc_sel     = 1'b1;
                    pc_write   = 1'b1;
                    ir1_load   = 1'b1;
                    ir1_squash = 1'b1;
                    ir2_bubble = 1'b1;
                end else if (hazard) begin
                    ir2_bubble = 1'b1;
                    stall      = 1'b1;
                end else if (ir1[3:0] == STOP_OP) begin
                    ir1_load   = 1'b1;
                    ir1_squash = 1'b1;
                    advance    = 1'b1;
                    next_state = ST_DRAIN;
                end else begin
                    pc_write = 1'b1;
                    ir1_load = 1'b1;
                    advance  = 1'b1;
                end
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
        if (!resetn) begin
            pc_write   = 1'b0;
            pc_sel     = 1'b0;
            ir1_load   = 1'b0;
            ir1_squash = 1'b0;
            ir2_bubble = 1'b0;
            stall      = 1'b0;
            halted     = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_RUN;
            sb          <= '0;
            drain_cnt   <= '0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            sb[2] <= sb[1];
            sb[1] <= sb[0];
            sb[0].valid <= advance && dec_wr && !is_bubble;
            sb[0].dest  <= dec_dest;
            drain_cnt   <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
